// File: rtl/pattern_pkg.sv
// pattern_pkg: shared types and defaults for the pattern_tx serializer.
//   state_t    : FSM state encoding (IDLE/SEND/PAR/DONE)
//   PAT_W_DEF  : default pattern length in bits
//   REP_W_DEF  : default width of the repeat-count input
package pattern_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int REP_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: request/stream bundle between a requester and pattern_tx.
//   start     : request to send (requester -> tx)
//   pat       : pattern, MSB sent first (requester -> tx)
//   reps      : repetition count, 0 treated as 1 (requester -> tx)
//   out       : serial bit (tx -> requester)
//   out_valid : out carries a pattern or parity bit (tx -> requester)
//   busy      : transfer in progress (tx -> requester)
//   done      : one-cycle pulse after the last bit (tx -> requester)
// Modports: master = requester side, slave = pattern_tx side.
interface pattern_tx_if #(
  parameter int PAT_W = pattern_pkg::PAT_W_DEF,
  parameter int REP_W = pattern_pkg::REP_W_DEF
) ();

  logic             start;
  logic [PAT_W-1:0] pat;
  logic [REP_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pat, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pat, reps,
    output out, out_valid, busy, done
  );

endinterface

// File: rtl/pattern_bit_cnt.sv
// pattern_bit_cnt: loadable down-counter with terminal-count flag.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; the count saturates at 0, never wraps
//   tc       : count is at or below the terminal value TC
// tc is a plain compare on the current count, so callers see the terminal
// condition before the decrement that would cross it.
module pattern_bit_cnt #(
  parameter int W  = 3,
  parameter int TC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt <= TC_V);

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serializes a captured pattern MSB first, repeated reps times
// (0 means once) back to back, optionally followed by an even-parity bit
// after each repetition.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; abandons any transfer
//   bus   : pattern_tx_if.slave (start/pat/reps in, out/out_valid/busy/done out)
// Build option: define PATTERN_TX_PARITY_EN to add the PAR state and parity
// bit; without it SEND goes straight to reload or DONE.
// PAT_W must be at least 2.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SEND  | shifting pattern bits onto out
// PAR   | emitting parity of the captured pattern (parity builds only)
// DONE  | one-cycle done pulse, then back to IDLE
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  pattern_tx_if.slave  bus
);

  localparam int              IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  state_t           state;
  // Bits still to be sent after the one currently on out.
  logic [PAT_W-2:0] shreg;
  logic [PAT_W-1:0] pat_cap;

  logic out_r;
  logic valid_r;
  logic busy_r;
  logic done_r;

  logic accept;
  logic idx_tc;
  logic rep_tc;
  logic pat_end;
  logic reload;

  assign accept = (state == IDLE) && bus.start;

`ifdef PATTERN_TX_PARITY_EN
  logic par_bit;
  assign par_bit = ^pat_cap;
  assign pat_end = (state == PAR);
`else
  assign pat_end = (state == SEND) && idx_tc;
`endif

  // Repeat counter holds the raw count; "> 1" means another repetition.
  assign reload = pat_end && !rep_tc;

  pattern_bit_cnt #(.W(IDX_W), .TC(0)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .load     (accept || reload),
    .load_val (IDX_TOP),
    .dec      ((state == SEND) && !idx_tc),
    .tc       (idx_tc)
  );

  pattern_bit_cnt #(.W(REP_W), .TC(1)) u_rep (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.reps),
    .dec      (reload),
    .tc       (rep_tc)
  );

  // Outputs are registered alongside the state so they describe the state
  // being entered; nothing reaches the bus combinationally from inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_cap <= '0;
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state   <= SEND;
            pat_cap <= bus.pat;
            shreg   <= bus.pat[PAT_W-2:0];
            out_r   <= bus.pat[PAT_W-1];
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end

        SEND: begin
          if (!idx_tc) begin
            shreg <= shreg << 1;
            out_r <= shreg[PAT_W-2];
          end
`ifdef PATTERN_TX_PARITY_EN
          else begin
            state <= PAR;
            out_r <= par_bit;
          end
`else
          else if (!rep_tc) begin
            shreg <= pat_cap[PAT_W-2:0];
            out_r <= pat_cap[PAT_W-1];
          end else begin
            state   <= DONE;
            out_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b1;
          end
`endif
        end

`ifdef PATTERN_TX_PARITY_EN
        PAR: begin
          if (!rep_tc) begin
            state <= SEND;
            shreg <= pat_cap[PAT_W-2:0];
            out_r <= pat_cap[PAT_W-1];
          end else begin
            state   <= DONE;
            out_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b1;
          end
        end
`endif

        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          out_r   <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed bench for pattern_tx with PAT_W=4, REP_W=3.
// Expected streams are hand-written for both builds (PATTERN_TX_PARITY_EN).
module tb_pattern_tx;

  logic clk = 1'b0;
  logic reset;

  pattern_tx_if #(.PAT_W(4), .REP_W(3)) bus ();

  pattern_tx #(.PAT_W(4), .REP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef PATTERN_TX_PARITY_EN
  localparam int          LEN     = 5;
  localparam logic [15:0] EXP_1011_R1 = 16'h0017;  // 1011 1
  localparam logic [15:0] EXP_1011_R2 = 16'h02F7;  // 1011 1 1011 1
  localparam logic [15:0] EXP_1011_R3 = 16'h5EF7;  // (1011 1) x3
  localparam logic [15:0] EXP_0110_R0 = 16'h000C;  // 0110 0
`else
  localparam int          LEN     = 4;
  localparam logic [15:0] EXP_1011_R1 = 16'h000B;  // 1011
  localparam logic [15:0] EXP_1011_R2 = 16'h00BB;  // 1011 1011
  localparam logic [15:0] EXP_1011_R3 = 16'h0BBB;  // 1011 1011 1011
  localparam logic [15:0] EXP_0110_R0 = 16'h0006;  // 0110
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge. Starts a transfer and collects the stream
  // until busy drops. poke_at > 0 re-asserts start with different pat/reps
  // for one cycle at that point in the transfer.
  task automatic run_xfer(input logic [3:0] p, input logic [2:0] r, input int poke_at,
                          output logic [15:0] bits, output int nbits, output int first_at,
                          output int ndone, output logic gap);
    logic ended;
    logic finished;
    bits     = '0;
    nbits    = 0;
    first_at = -1;
    ndone    = 0;
    gap      = 1'b0;
    ended    = 1'b0;
    finished = 1'b0;
    bus.pat   = p;
    bus.reps  = r;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (ended) gap = 1'b1;
        if (first_at < 0) first_at = cyc;
        bits = {bits[14:0], bus.out};
        nbits++;
      end else if (first_at >= 0) begin
        ended = 1'b1;
      end
      if (bus.done) ndone++;
      bus.start = (cyc == poke_at);
      if (cyc == poke_at) begin
        bus.pat  = 4'b1111;
        bus.reps = 3'd5;
      end
      if (!bus.busy) begin
        finished = 1'b1;
        check("idle_out", {31'd0, bus.out}, 32'd0);
        break;
      end
    end
    if (!finished) check("xfer_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  logic [15:0] bits;
  int          nbits, first_at, ndone;
  logic        gap;

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.pat   = '0;
    bus.reps  = '0;
    repeat (3) @(negedge clk);

    check("rst_out",   {31'd0, bus.out},       32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},      32'd0);
    check("rst_done",  {31'd0, bus.done},      32'd0);

    reset = 1'b1;

    // single pattern; start offered on the first edge after release
    run_xfer(4'b1011, 3'd1, 0, bits, nbits, first_at, ndone, gap);
    check("r1_first", first_at, 32'd1);
    check("r1_bits",  {16'd0, bits}, {16'd0, EXP_1011_R1});
    check("r1_n",     nbits, LEN);
    check("r1_done",  ndone, 32'd1);
    check("r1_gap",   {31'd0, gap}, 32'd0);

    run_xfer(4'b1011, 3'd3, 0, bits, nbits, first_at, ndone, gap);
    check("r3_bits",  {16'd0, bits}, {16'd0, EXP_1011_R3});
    check("r3_n",     nbits, 3 * LEN);
    check("r3_gap",   {31'd0, gap}, 32'd0);
    check("r3_done",  ndone, 32'd1);

    run_xfer(4'b1011, 3'd2, 0, bits, nbits, first_at, ndone, gap);
    check("r2_bits",  {16'd0, bits}, {16'd0, EXP_1011_R2});
    check("r2_n",     nbits, 2 * LEN);

    run_xfer(4'b0110, 3'd0, 0, bits, nbits, first_at, ndone, gap);
    check("r0_bits",  {16'd0, bits}, {16'd0, EXP_0110_R0});
    check("r0_n",     nbits, LEN);
    check("r0_done",  ndone, 32'd1);

    // start with pat=1111/reps=5 offered mid-SEND must be ignored
    run_xfer(4'b1011, 3'd1, 2, bits, nbits, first_at, ndone, gap);
    check("poke_bits", {16'd0, bits}, {16'd0, EXP_1011_R1});
    check("poke_n",    nbits, LEN);
    check("poke_done", ndone, 32'd1);
    @(negedge clk);
    check("poke_busy", {31'd0, bus.busy}, 32'd0);

    // async reset during the third bit
    bus.pat   = 4'b1011;
    bus.reps  = 3'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_bit3",  {31'd0, bus.out},       32'd1);
    check("ar_val3",  {31'd0, bus.out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_out",   {31'd0, bus.out},       32'd0);
    check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_busy",  {31'd0, bus.busy},      32'd0);
    check("ar_done",  {31'd0, bus.done},      32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_xfer(4'b1011, 3'd1, 0, bits, nbits, first_at, ndone, gap);
    check("ar_first", first_at, 32'd1);
    check("ar_bits",  {16'd0, bits}, {16'd0, EXP_1011_R1});
    check("ar_n",     nbits, LEN);

    // start held high: one DONE and one IDLE cycle between transfers
    begin
      int vcnt = 0;
      int last1 = -1;
      int first2 = -1;
      logic idle_seen = 1'b0;
      bus.pat   = 4'b1011;
      bus.reps  = 3'd1;
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          vcnt++;
          if (vcnt == LEN) last1 = cyc;
          if (vcnt == LEN + 1) begin
            first2 = cyc;
            bus.start = 1'b0;
            break;
          end
        end
      end
      bus.start = 1'b0;
      check("b2b_spacing", first2 - last1, 32'd3);
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(negedge clk);
        if (!bus.busy) begin
          idle_seen = 1'b1;
          break;
        end
      end
      check("b2b_idle", {31'd0, idle_seen}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, minimum 2.
REQ-002 Parameter REP_W, default 3: width of the repeat-count input.
REQ-003 The block SHALL have one clock, clk, and reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to send; sampled only in IDLE.
REQ-007 pat  input  PAT_W  pattern to serialize, MSB first; captured on an accepted start.
REQ-008 reps  input  REP_W  number of back-to-back pattern repetitions; captured on an accepted start; 0 means 1.
REQ-009 out  output  1  serial bit stream, registered.
REQ-010 out_valid  output  1  high when out carries a pattern or parity bit.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last bit.

Function
REQ-013 The block SHALL be a Moore FSM: all outputs decode from registered state only, with no combinational path from inputs to outputs.
REQ-014 States SHALL be IDLE, SEND, PAR, DONE.
REQ-015 Transitions:
- IDLE -> SEND on start=1. pat is loaded into the shift register, reps is loaded into the repeat counter, and the bit index is set to PAT_W-1.
- SEND -> SEND while bit index > 0; the shift register shifts left and the bit index decrements.
- SEND at bit index 0 -> PAR if parity is enabled; otherwise -> SEND (reload) or -> DONE.
- PAR -> SEND (reload) or -> DONE.
- DONE -> IDLE unconditionally.
REQ-016 A reload SHALL occur when the repeat counter > 1. The counter decrements and the shift register reloads from the captured pattern, with no idle gap between repetitions.
REQ-017 Latency: when start is sampled at edge k, the first bit (pat[PAT_W-1]) SHALL be on out with out_valid=1 during the cycle after edge k.
REQ-018 A transfer SHALL emit exactly max(reps,1) × (PAT_W + P) consecutive valid bits, where P=1 with parity enabled and 0 otherwise. done follows the last bit in the next cycle.
REQ-019 In IDLE and DONE, out SHALL be 0 and out_valid SHALL be 0.
REQ-020 start SHALL be ignored in SEND, PAR and DONE; changes to pat and reps after capture SHALL have no effect.
REQ-021 start held high continuously SHALL begin a new transfer on the first IDLE cycle after DONE, so back-to-back transfers are separated by exactly one DONE cycle and one IDLE cycle.
REQ-022 The bit index and repeat counter SHALL NOT wrap. Terminal values are detected before decrement.

Reset
REQ-023 Assertion of reset SHALL immediately force IDLE and drive out=0, out_valid=0, busy=0, done=0. This applies mid-transfer, and a partial transfer is abandoned.
REQ-024 After deassertion, the block SHALL accept start on the first rising edge of clk.

Configuration
REQ-025 Macro PATTERN_TX_PARITY_EN:
- Defined: the PAR state SHALL exist and emit one even-parity bit (XOR of the captured pattern) after each pattern repetition, with out_valid=1.
- Undefined: the PAR state and its logic SHALL be absent, and SEND proceeds directly to reload or DONE.

Structure
REQ-026 Package pattern_pkg SHALL hold:
- the state typedef (IDLE/SEND/PAR/DONE);
- default constants PAT_W_DEF=4 and REP_W_DEF=3.
REQ-027 A single sub-module, pattern_bit_cnt (a loadable down-counter with a terminal-count flag), SHALL be instantiated twice: once as the bit index and once as the repeat counter.

Verification (PAT_W=4)
REQ-028 Reset released, then start=1 for one cycle with pat=1011, reps=1, parity off -> out=1,0,1,1 on 4 cycles with out_valid=1, then done=1 for one cycle, then busy=0.
REQ-029 pat=1011, reps=3, parity off -> 12 contiguous valid bits 1011 1011 1011 with no gap, then one done pulse.
REQ-030 PATTERN_TX_PARITY_EN defined, pat=1011, reps=2 -> 1011 1 1011 1 (10 bits), then done.
REQ-031 reps=0, pat=0110 -> sent exactly once: 0,1,1,0.
REQ-032 start pulsed during SEND with pat=1111 -> ignored; the original 1011 stream completes unchanged.
REQ-033 reset asserted in the third bit of 1011 -> out, out_valid and busy go to 0 immediately, without waiting for a clock edge; a new start after release transmits the full pattern from its MSB.
